// File: rtl/spi_cfg_controller.sv
// SPI write-only host: turns register-write requests into 16-bit mode-0 frames {1, addr[6:0], data[7:0]}.
// Define REQ_FIFO_EN to put a FIFO_DEPTH-entry request FIFO in front of the frame engine.
module spi_cfg_controller #(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       cs_n
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [15:0]   shreg, shreg_d;
  logic          phase_hi, phase_hi_d;
  logic          sclk_d, copi_d, cs_n_d, done_d, busy_d, ready_d;
  logic          start, queued;
  logic [6:0]    start_addr;
  logic [7:0]    start_data;

  // The receiver double-syncs sclk, so each phase needs at least 3 clk cycles.
  if (CLK_DIV < 3) begin : g_div_chk
    always @(posedge clk) $error("spi_cfg_controller: CLK_DIV=%0d is below the minimum of 3", CLK_DIV);
  end

`ifdef REQ_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_d;
  logic          push;

  assign push                     = req_valid && req_ready;
  assign start                    = (state == IDLE) && (level != '0);
  assign {start_addr, start_data} = mem[rd_ptr];
  assign level_d                  = level + (AW+1)'(push) - (AW+1)'(start);
  assign ready_d                  = (level_d != (AW+1)'(FIFO_DEPTH));
  assign queued                   = (level_d != '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (start) rd_ptr <= rd_ptr + 1'b1;
      level <= level_d;
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_addr, req_data};
`else
  assign start      = (state == IDLE) && req_valid && req_ready;
  assign start_addr = req_addr;
  assign start_data = req_data;
  assign ready_d    = (state_d == IDLE);
  assign queued     = 1'b0;
`endif

  assign busy_d = (state_d != IDLE) || queued;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    phase_hi_d = phase_hi;
    sclk_d     = sclk;
    copi_d     = copi;
    cs_n_d     = cs_n;
    done_d     = 1'b0;
    case (state)
      IDLE: if (start) begin
        shreg_d   = {1'b1, start_addr, start_data};
        bit_cnt_d = 4'd15;
        copi_d    = 1'b1;
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        cnt_d     = CW'(CS_SETUP - 1);
        state_d   = SETUP;
      end
      SETUP: if (cnt == '0) begin
        phase_hi_d = 1'b0;
        cnt_d      = CW'(CLK_DIV - 1);
        state_d    = SHIFT;
      end else cnt_d = cnt - 1'b1;
      SHIFT: if (cnt != '0) cnt_d = cnt - 1'b1;
      else if (!phase_hi) begin
        sclk_d     = 1'b1;
        phase_hi_d = 1'b1;
        cnt_d      = CW'(CLK_DIV - 1);
      end else begin
        // Falling edge: next bit goes out on copi in the same cycle.
        sclk_d     = 1'b0;
        phase_hi_d = 1'b0;
        cnt_d      = CW'(CLK_DIV - 1);
        if (bit_cnt == '0) begin
          copi_d  = 1'b0;
          cnt_d   = CW'(CS_HOLD - 1);
          state_d = HOLD;
        end else begin
          shreg_d   = {shreg[14:0], 1'b0};
          copi_d    = shreg[14];
          bit_cnt_d = bit_cnt - 1'b1;
        end
      end
      HOLD: if (cnt == '0) begin
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        cnt_d   = CW'(CS_IDLE - 1);
        state_d = GAP;
      end else cnt_d = cnt - 1'b1;
      GAP: if (cnt == '0) state_d = IDLE;
      else cnt_d = cnt - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      phase_hi  <= 1'b0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      cs_n      <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      phase_hi  <= phase_hi_d;
      sclk      <= sclk_d;
      copi      <= copi_d;
      cs_n      <= cs_n_d;
      done      <= done_d;
      busy      <= busy_d;
      req_ready <= ready_d;
    end

endmodule
